// File: rtl/sdp_rdma_pkg.sv
// Shared constants and helpers for the SDP read-DMA data unpacker.
// Holds the field offsets of the command and response payloads and the layer state type.
package sdp_rdma_pkg;

  localparam int ATOM_W      = 256;
  localparam int SIZE_W      = 14;
  localparam int STALL_W     = 32;
  localparam int CMD_W       = SIZE_W + 1;
  localparam int RSP_W       = 2 * ATOM_W + 2;
  localparam int IS_LAST_BIT = SIZE_W;
  localparam int MASK_LSB    = 2 * ATOM_W;

  typedef enum logic {
    LAYER_IDLE,
    LAYER_RUN
  } layer_state_e;

  // A two-bit remaining mask holds exactly one half when its bits differ.
  function automatic logic is_last_half(input logic [1:0] rem);
    return rem[0] ^ rem[1];
  endfunction

endpackage

// File: rtl/sdp_rdma_unpack_buf.sv
// One-entry response buffer for the read-DMA unpacker.
// It holds a 512-bit response and a mask of the halves not yet sent, and presents the lower pending half first.
module sdp_rdma_unpack_buf
  import sdp_rdma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_en,
  input  logic              rsp_pvld,
  input  logic [RSP_W-1:0]  rsp_pd,
  input  logic              out_acc,
  output logic              rsp_prdy,
  output logic              buf_vld,
  output logic              mask_zero_acc,
  output logic [ATOM_W-1:0] out_pd
);

  logic [2*ATOM_W-1:0] buf_data;
  logic [1:0]          rem;
  logic [1:0]          rsp_mask;
  logic [1:0]          sel_bit;
  logic                last_half;
  logic                rsp_acc;

  assign rsp_mask      = rsp_pd[MASK_LSB +: 2];
  assign buf_vld       = |rem;
  assign last_half     = is_last_half(rem);
  assign rsp_prdy      = op_en & (!buf_vld | (out_acc & last_half));
  assign rsp_acc       = rsp_pvld & rsp_prdy;
  assign mask_zero_acc = rsp_acc & (rsp_mask == 2'b00);
  assign sel_bit       = rem[0] ? 2'b01 : 2'b10;
  assign out_pd        = rem[0] ? buf_data[ATOM_W-1:0] : buf_data[2*ATOM_W-1:ATOM_W];

  // A refill accepted while the final half drains overrides the drain, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= 2'b00;
      buf_data <= '0;
    end else begin
      if (out_acc) begin
        rem <= rem & ~sel_bit;
      end
      if (rsp_acc && (rsp_mask != 2'b00)) begin
        rem      <= rsp_mask;
        buf_data <= rsp_pd[2*ATOM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdp_rdma_dat_unpack.sv
// SDP read-DMA data unpacker: splits 512-bit read responses into 256-bit atoms,
// counts atoms against RDMA commands, and reports layer done, mask errors and stall cycles.
module sdp_rdma_dat_unpack
  import sdp_rdma_pkg::*;
(
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               op_load,
  input  logic               cmd2dat_pvld,
  output logic               cmd2dat_prdy,
  input  logic [CMD_W-1:0]   cmd2dat_pd,
  input  logic               dma_rd_rsp_pvld,
  output logic               dma_rd_rsp_prdy,
  input  logic [RSP_W-1:0]   dma_rd_rsp_pd,
  output logic               sdp_rdma2dp_valid,
  input  logic               sdp_rdma2dp_ready,
  output logic [ATOM_W-1:0]  sdp_rdma2dp_pd,
  output logic               sdp_rdma2dp_last,
  output logic               dp2reg_done,
  output logic               dp2reg_status_mask_err,
  output logic [STALL_W-1:0] dp2reg_rd_stall
);

  layer_state_e      state;
  layer_state_e      state_nxt;
  logic              op_en;
  logic              buf_vld;
  logic              mask_zero_acc;
  logic              out_acc;
  logic              cmd_is_last;
  logic [SIZE_W-1:0] cmd_size;
  logic [SIZE_W-1:0] cnt;
  logic              cnt_end;
  logic              layer_end;
  logic              layer_start;

  sdp_rdma_unpack_buf u_buf (
    .clk           (nvdla_core_clk),
    .rst           (nvdla_core_rst),
    .op_en         (op_en),
    .rsp_pvld      (dma_rd_rsp_pvld),
    .rsp_pd        (dma_rd_rsp_pd),
    .out_acc       (out_acc),
    .rsp_prdy      (dma_rd_rsp_prdy),
    .buf_vld       (buf_vld),
    .mask_zero_acc (mask_zero_acc),
    .out_pd        (sdp_rdma2dp_pd)
  );

  assign cmd_is_last       = cmd2dat_pd[IS_LAST_BIT];
  assign cmd_size          = cmd2dat_pd[SIZE_W-1:0];
  assign cnt_end           = (cnt == cmd_size);
  assign sdp_rdma2dp_valid = buf_vld & cmd2dat_pvld;
  assign out_acc           = sdp_rdma2dp_valid & sdp_rdma2dp_ready;
  assign cmd2dat_prdy      = out_acc & cnt_end;
  assign sdp_rdma2dp_last  = sdp_rdma2dp_valid & cmd_is_last & cnt_end;
  assign layer_end         = out_acc & cmd_is_last & cnt_end;
  assign op_en             = (state == LAYER_RUN);
  assign layer_start       = op_load & !op_en;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= LAYER_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A second op_load while running is ignored; the final atom returns the layer to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      LAYER_IDLE: if (op_load)   state_nxt = LAYER_RUN;
      LAYER_RUN:  if (layer_end) state_nxt = LAYER_IDLE;
      default:                   state_nxt = LAYER_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt <= '0;
    end else if (out_acc) begin
      cnt <= cnt_end ? '0 : cnt + SIZE_W'(1);
    end
  end

  // Status registers are cleared by the start of a new layer; the stall counter saturates.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dp2reg_done            <= 1'b0;
      dp2reg_status_mask_err <= 1'b0;
      dp2reg_rd_stall        <= '0;
    end else begin
      dp2reg_done <= layer_end;
      if (layer_start) begin
        dp2reg_status_mask_err <= 1'b0;
        dp2reg_rd_stall        <= '0;
      end else begin
        if (mask_zero_acc) begin
          dp2reg_status_mask_err <= 1'b1;
        end
        if (op_en && !buf_vld && (dp2reg_rd_stall != '1)) begin
          dp2reg_rd_stall <= dp2reg_rd_stall + STALL_W'(1);
        end
      end
    end
  end

endmodule
